// File: rtl/lwc_pkg.sv
// Shared definitions for the LWC data-out receiver: segment type codes,
// header field positions, FSM state encoding, FIFO entry layout and
// small helpers used to decode segment headers.
package lwc_pkg;

  // Segment / status type codes carried in header bits [31:28]
  localparam logic [3:0] SEG_PT   = 4'h4;
  localparam logic [3:0] SEG_CT   = 4'h5;
  localparam logic [3:0] SEG_TAG  = 4'h8;
  localparam logic [3:0] SEG_OK   = 4'hE;
  localparam logic [3:0] SEG_FAIL = 4'hF;

  // Header field positions
  localparam int HDR_TYPE_MSB = 31;
  localparam int HDR_TYPE_LSB = 28;
  localparam int HDR_LEN_MSB  = 15;
  localparam int HDR_LEN_LSB  = 0;

  // Receiver FSM states
  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  // One FIFO entry: payload word plus its segment attributes (40 bits)
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  typ;
    logic [2:0]  bytes;
    logic        eot;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Status words use the two top type codes
  function automatic logic is_status(input logic [3:0] t);
    return (t == SEG_OK) || (t == SEG_FAIL);
  endfunction

  // Segment types a well-formed stream may carry
  function automatic logic legal_seg_type(input logic [3:0] t);
    return (t == SEG_PT) || (t == SEG_CT) || (t == SEG_TAG);
  endfunction

  // Number of 32-bit words needed for len bytes, rounded up
  function automatic logic [14:0] word_count(input logic [15:0] len);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'd3;
    return sum[16:2];
  endfunction

  // Valid bytes in the final word of a segment (1..4)
  function automatic logic [2:0] last_bytes(input logic [15:0] len);
    return (len[1:0] == 2'd0) ? 3'd4 : {1'b0, len[1:0]};
  endfunction

endpackage

// File: rtl/lwc_fifo.sv
// First-word-fall-through FIFO with occupancy count. Push while full is
// accepted only together with a pop; pointers wrap modulo DEPTH (a power
// of two). The read port shows zero whenever the FIFO is empty.
module lwc_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty_s, full_s, do_push_s, do_pop_s;

  assign empty_s   = (cnt_q == '0);
  assign full_s    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop_s  = pop_i && !empty_s;
  assign do_push_s = push_i && (!full_s || do_pop_s);

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_s) wr_q <= wr_q + AW'(1);
      if (do_pop_s)  rd_q <= rd_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are only meaningful where count covers them
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o = empty_s ? '0 : mem_q[rd_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/lwc_do_receiver.sv
// LWC data-out receiver: parses segment headers and status words from the
// cipher core's do stream, forwards payload words with type/byte-count/eot
// through an output FIFO, and reports done/pass once the result drains.
// Optional protocol checking is enabled by defining LWC_DO_RECEIVER_CHECK_EN.
module lwc_do_receiver
  import lwc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] do_data,
  input  logic        do_valid,
  input  logic        do_last,
  output logic        do_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_type,
  output logic [2:0]  out_bytes,
  output logic        out_eot,
  output logic        done,
  output logic        pass,
  output logic        err
);

`ifdef LWC_DO_RECEIVER_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  localparam int CW = $clog2(DEPTH) + 1;

  state_e      state_q, state_d;
  logic [14:0] rem_q, rem_d;
  logic [3:0]  type_q, type_d;
  logic [2:0]  lastb_q, lastb_d;
  logic        pass_q, pass_d;
  logic        err_q, err_d;
  logic        rdy_en_q;

  logic [CW-1:0] count_s;
  logic          accept_s, push_s, done_s, fifo_empty_s, hdr_bad_s;
  logic [3:0]    hdr_type_s;
  logic [15:0]   hdr_len_s;
  fifo_entry_t   push_entry_s, pop_entry_s;

  assign hdr_type_s   = do_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
  assign hdr_len_s    = do_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign fifo_empty_s = (count_s == '0);
  assign do_ready     = rdy_en_q && (count_s < CW'(DEPTH)) && (state_q != S_WAIT);
  assign accept_s     = do_valid && do_ready;

  // A header is malformed if it carries do_last or an unknown type; a
  // status word is malformed if it does not close the stream.
  always_comb begin
    hdr_bad_s = 1'b0;
    if (is_status(hdr_type_s)) begin
      hdr_bad_s = !do_last;
    end else begin
      hdr_bad_s = do_last || !legal_seg_type(hdr_type_s);
    end
  end

  // Next-state and datapath control for the stream parser
  always_comb begin
    state_d            = state_q;
    rem_d              = rem_q;
    type_d             = type_q;
    lastb_d            = lastb_q;
    pass_d             = pass_q;
    err_d              = err_q;
    push_s             = 1'b0;
    done_s             = 1'b0;
    push_entry_s.data  = do_data;
    push_entry_s.typ   = type_q;
    push_entry_s.bytes = 3'd4;
    push_entry_s.eot   = 1'b0;
    case (state_q)
      S_HDR: begin
        if (accept_s) begin
          if (CHECK_EN && hdr_bad_s) begin
            err_d   = 1'b1;
            pass_d  = 1'b0;
            state_d = S_ERR;
          end else if (is_status(hdr_type_s)) begin
            pass_d  = (hdr_type_s == SEG_OK);
            state_d = S_WAIT;
          end else begin
            type_d  = hdr_type_s;
            rem_d   = word_count(hdr_len_s);
            lastb_d = last_bytes(hdr_len_s);
            state_d = (hdr_len_s != 16'd0) ? S_DATA : S_HDR;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          if (CHECK_EN && do_last) begin
            err_d   = 1'b1;
            pass_d  = 1'b0;
            state_d = S_ERR;
          end else begin
            push_s = 1'b1;
            rem_d  = rem_q - 15'd1;
            if (rem_q == 15'd1) begin
              push_entry_s.bytes = lastb_q;
              push_entry_s.eot   = 1'b1;
              state_d            = S_HDR;
            end else begin
              state_d = S_DATA;
            end
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WAIT: begin
        if (fifo_empty_s) begin
          done_s  = 1'b1;
          state_d = S_HDR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ERR: begin
        if (accept_s && do_last) begin
          pass_d  = 1'b0;
          state_d = S_WAIT;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // FSM and segment context registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HDR;
      rem_q   <= 15'd0;
      type_q  <= 4'd0;
      lastb_q <= 3'd0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      lastb_q <= lastb_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  // Keeps do_ready low for the first cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  lwc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (out_ready),
    .pop_data_o  (pop_entry_s),
    .count_o     (count_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_data  = pop_entry_s.data;
  assign out_type  = pop_entry_s.typ;
  assign out_bytes = pop_entry_s.bytes;
  assign out_eot   = pop_entry_s.eot;
  assign done      = done_s;
  assign pass      = pass_q;
  assign err       = CHECK_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_lwc_do_receiver.sv
// Scoreboard bench for lwc_do_receiver: stimulus pushes expected payload
// entries into a queue, an independent monitor pops and compares on every
// output handshake. Directed streams plus randomized segment traffic.
module tb_lwc_do_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] do_data;
  logic        do_valid, do_last, do_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_type;
  logic [2:0]  out_bytes;
  logic        out_eot, done, pass, err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int n_status = 0;
  int rmode = 2;           // 0 random out_ready, 1 hold low, 2 hold high
  logic [39:0] sbq[$];

  lwc_do_receiver #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .do_data(do_data), .do_valid(do_valid),
    .do_last(do_last), .do_ready(do_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_bytes(out_bytes), .out_eot(out_eot), .done(done), .pass(pass),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare every output transfer against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst && done) done_cnt++;
      if (rst && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got %0h expected none", {out_data, out_type, out_bytes, out_eot});
        end else begin
          chk("out_word", {out_data, out_type, out_bytes, out_eot}, sbq.pop_front());
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last, input int budget, output bit ok);
    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    do_data = d; do_last = last; do_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (do_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    do_valid = 1'b0; do_last = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit ok;
    send_word(d, last, 400, ok);
    chk("accept", ok, 1);
  endtask

  // Expected entry for word idx of a segment of len bytes
  function automatic logic [39:0] exp_entry(input logic [31:0] d, input logic [3:0] t, input int len, input int idx);
    int words, left, b;
    words = (len + 3) / 4;
    left  = len - 4 * idx;
    b     = (left >= 4) ? 4 : left;
    return {d, t, 3'(b), (idx == words - 1) ? 1'b1 : 1'b0};
  endfunction

  task automatic send_seg(input logic [3:0] t, input int len);
    logic [31:0] d;
    send({t, 12'($urandom), 16'(len)}, 1'b0);
    for (int i = 0; i < (len + 3) / 4; i++) begin
      d = $urandom;
      sbq.push_back(exp_entry(d, t, len, i));
      send(d, 1'b0);
    end
  endtask

  task automatic send_status(input logic ok_code);
    send(ok_code ? 32'hE000_0000 : 32'hF000_0000, 1'b1);
    n_status++;
  endtask

  task automatic wait_done(input logic ep, input logic ee, output int lat);
    bit seen;
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk); lat++;
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("drained_at_done", out_valid, 0);
      chk("sb_empty_at_done", sbq.size(), 0);
      chk("pass", pass, ep);
      chk("err", err, ee);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_027(input logic ee);
    int lat;
    send(32'h4000_0006, 1'b0);
    sbq.push_back({32'h1122_3344, 4'h4, 3'd4, 1'b0});
    send(32'h1122_3344, 1'b0);
    sbq.push_back({32'h5566_ABCD, 4'h4, 3'd2, 1'b1});
    send(32'h5566_ABCD, 1'b0);
    send_status(1'b1);
    wait_done(1'b1, ee, lat);
  endtask

  initial begin
    int lat;
    bit ok;
    rst = 1'b0; do_valid = 1'b0; do_last = 1'b0; do_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_do_ready", do_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_out_fields", {out_data, out_type, out_bytes, out_eot}, 40'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); chk("ready_first_cycle", do_ready, 0);
    @(negedge clk); chk("ready_second_cycle", do_ready, 1);
    @(posedge clk); #1;

    // Two-word PT segment with partial last word, OK status
    run_027(1'b0);

    // Four-word tag segment, FAIL status
    send(32'h8000_0010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = 32'hA0A0_0000 + 32'(i);
      sbq.push_back({d, 4'h8, 3'd4, (i == 3) ? 1'b1 : 1'b0});
      send(d, 1'b0);
    end
    send_status(1'b0);
    wait_done(1'b0, 1'b0, lat);

    // Zero-length segment: no output, done one cycle after status
    send(32'h5000_0000, 1'b0);
    send_status(1'b1);
    wait_done(1'b1, 1'b0, lat);
    chk("done_latency", lat, 1);

    // Backpressure: FIFO fills after four words, then drains in order
    rmode = 1;
    send(32'h4000_0018, 1'b0);
    for (int i = 0; i < 6; i++)
      sbq.push_back({32'hC0DE_0000 + 32'(i), 4'h4, 3'd4, (i == 5) ? 1'b1 : 1'b0});
    for (int i = 0; i < 4; i++) send(32'hC0DE_0000 + 32'(i), 1'b0);
    send_word(32'hC0DE_0004, 1'b0, 8, ok);
    chk("full_stall", ok, 0);
    @(negedge clk); chk("full_ready_low", do_ready, 0);
    chk("full_out_valid", out_valid, 1);
    @(posedge clk); #1;
    rmode = 2;
    send(32'hC0DE_0004, 1'b0);
    send(32'hC0DE_0005, 1'b0);
    send_status(1'b1);
    wait_done(1'b1, 1'b0, lat);

    // Protocol violation: do_last on a payload word
    send(32'h4000_0008, 1'b0);
    sbq.push_back({32'h1234_5678, 4'h4, 3'd4, 1'b0});
    send(32'h1234_5678, 1'b0);
`ifdef LWC_DO_RECEIVER_CHECK_EN
    send(32'h9999_0000, 1'b1);
    send(32'h4000_0004, 1'b0);
    send(32'h7777_7777, 1'b0);
    send_status(1'b1);
    wait_done(1'b0, 1'b1, lat);
`else
    sbq.push_back({32'h9999_0000, 4'h4, 3'd4, 1'b1});
    send(32'h9999_0000, 1'b1);
    send_status(1'b1);
    wait_done(1'b1, 1'b0, lat);
`endif

    // Randomized segment traffic against the scoreboard
    rmode = 0;
    for (int it = 0; it < 20; it++) begin
      int nseg;
      logic st;
      logic [3:0] t;
      nseg = $urandom_range(1, 3);
      for (int s = 0; s < nseg; s++) begin
        case ($urandom_range(0, 2))
          0:       t = 4'h4;
          1:       t = 4'h5;
          default: t = 4'h8;
        endcase
        send_seg(t, $urandom_range(0, 20));
      end
      st = 1'($urandom_range(0, 1));
      send_status(st);
      wait_done(st, 1'b0, lat);
    end

    // Reset in mid-segment with three words buffered
    rmode = 1;
    repeat (2) @(posedge clk); #1;
    send(32'h4000_0010, 1'b0);
    for (int i = 0; i < 3; i++) send(32'hDEAD_0000 + 32'(i), 1'b0);
    @(negedge clk); chk("pre_reset_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_do_ready", do_ready, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_err", err, 0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); chk("rel_ready_first", do_ready, 0);
    @(negedge clk); chk("rel_ready_second", do_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rmode = 2;
    done_cnt = 0; n_status = 0;
    run_027(1'b0);

    repeat (3) @(posedge clk);
    chk("done_count", done_cnt, n_status);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
